// File: rtl/alu_regfile.sv
// Register-file ALU: NREGS x WIDTH operand bank, 3-address valid/ready commands, carry/zero flags.
// Optional shift-add multiplier (opcode 11) enabled by defining ALU_MUL_EN.
module alu_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [3:0]       i_cmd_op,
  input  logic [AW-1:0]    i_cmd_dst,
  input  logic [AW-1:0]    i_cmd_srca,
  input  logic [AW-1:0]    i_cmd_srcb,
  input  logic [WIDTH-1:0] i_cmd_data,
  output logic             o_res_valid,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_flag_carry,
  output logic             o_flag_zero,
  output logic             o_cmd_err,
  output logic             o_busy
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;
  localparam logic [3:0] OP_READ = 4'd10;

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_res_data;
  logic             r_carry;
  logic             r_zero;
  logic             r_res_valid;
  logic             r_cmd_err;

  logic               w_accept;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_shl;
  logic [2*WIDTH-1:0] w_shr;
  logic               w_zero_shift;
  logic               w_big_shift;
  logic [WIDTH-1:0]   w_result;
  logic               w_carry;
  logic               w_write;
  logic               w_flags;
  logic               w_pulse;
  logic               w_err;
  logic               w_mul_done;
  logic [WIDTH-1:0]   w_mul_lo;
  logic               w_mul_hi;
  logic [AW-1:0]      w_mul_dst;

  assign w_accept     = i_cmd_valid && o_cmd_ready;
  assign w_a          = r_regs[i_cmd_srca];
  assign w_b          = r_regs[i_cmd_srcb];
  assign w_sum        = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff       = {1'b0, w_a} - {1'b0, w_b};
  // Shifting into a double-width window leaves the last bit shifted out at the window seam.
  assign w_shl        = {{WIDTH{1'b0}}, w_a} << w_b;
  assign w_shr        = {w_a, {WIDTH{1'b0}}} >> w_b;
  assign w_zero_shift = (w_b == {WIDTH{1'b0}});
  assign w_big_shift  = (32'(w_b) >= 32'(WIDTH));

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;
  state_t r_state;
  state_t w_state_next;

  logic               w_mul_start;
  logic [CW-1:0]      r_mul_cnt;
  logic [2*WIDTH-1:0] r_mul_acc;
  logic [2*WIDTH-1:0] r_mul_mcand;
  logic [WIDTH-1:0]   r_mul_mplier;
  logic [AW-1:0]      r_mul_dst;
  logic [2*WIDTH-1:0] w_acc_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
               else             w_state_next = ST_IDLE;
      ST_MUL:  if (r_mul_cnt == CNT_LAST) w_state_next = ST_IDLE;
               else                       w_state_next = ST_MUL;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // One shift-add step per cycle; operands and destination are captured at accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mul_cnt    <= '0;
      r_mul_acc    <= '0;
      r_mul_mcand  <= '0;
      r_mul_mplier <= '0;
      r_mul_dst    <= '0;
    end else if (w_mul_start) begin
      r_mul_cnt    <= '0;
      r_mul_acc    <= '0;
      r_mul_mcand  <= {{WIDTH{1'b0}}, w_a};
      r_mul_mplier <= w_b;
      r_mul_dst    <= i_cmd_dst;
    end else if (r_state == ST_MUL) begin
      r_mul_cnt    <= r_mul_cnt + CW'(1);
      r_mul_acc    <= w_acc_next;
      r_mul_mcand  <= r_mul_mcand << 1;
      r_mul_mplier <= r_mul_mplier >> 1;
    end
  end

  assign w_acc_next  = r_mul_acc + (r_mul_mplier[0] ? r_mul_mcand : {2*WIDTH{1'b0}});
  assign w_mul_done  = (r_state == ST_MUL) && (r_mul_cnt == CNT_LAST);
  assign w_mul_lo    = w_acc_next[WIDTH-1:0];
  assign w_mul_hi    = |w_acc_next[2*WIDTH-1:WIDTH];
  assign w_mul_dst   = r_mul_dst;
  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state == ST_MUL);
`else
  assign w_mul_done  = 1'b0;
  assign w_mul_lo    = {WIDTH{1'b0}};
  assign w_mul_hi    = 1'b0;
  assign w_mul_dst   = {AW{1'b0}};
  assign o_cmd_ready = 1'b1;
  assign o_busy      = 1'b0;
`endif

  always_comb begin
    w_result = {WIDTH{1'b0}};
    w_carry  = 1'b0;
    w_write  = 1'b0;
    w_flags  = 1'b0;
    w_pulse  = 1'b0;
    w_err    = 1'b0;
`ifdef ALU_MUL_EN
    w_mul_start = 1'b0;
`endif
    if (w_accept) begin
      case (i_cmd_op)
        OP_NOP:  w_err = 1'b0;
        OP_LOAD: begin w_result = i_cmd_data; w_write = 1'b1; w_pulse = 1'b1; end
        OP_ADD:  begin w_result = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];
                       w_write = 1'b1; w_flags = 1'b1; w_pulse = 1'b1; end
        OP_SUB:  begin w_result = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH];
                       w_write = 1'b1; w_flags = 1'b1; w_pulse = 1'b1; end
        OP_AND:  begin w_result = w_a & w_b; w_write = 1'b1; w_flags = 1'b1; w_pulse = 1'b1; end
        OP_OR:   begin w_result = w_a | w_b; w_write = 1'b1; w_flags = 1'b1; w_pulse = 1'b1; end
        OP_XOR:  begin w_result = w_a ^ w_b; w_write = 1'b1; w_flags = 1'b1; w_pulse = 1'b1; end
        OP_SHL: begin
          if (w_zero_shift) begin
            w_result = w_a;
          end else if (w_big_shift) begin
            w_result = {WIDTH{1'b0}};
          end else begin
            w_result = w_shl[WIDTH-1:0];
            w_carry  = w_shl[WIDTH];
          end
          w_write = 1'b1; w_flags = 1'b1; w_pulse = 1'b1;
        end
        OP_SHR: begin
          if (w_zero_shift) begin
            w_result = w_a;
          end else if (w_big_shift) begin
            w_result = {WIDTH{1'b0}};
          end else begin
            w_result = w_shr[2*WIDTH-1:WIDTH];
            w_carry  = w_shr[WIDTH-1];
          end
          w_write = 1'b1; w_flags = 1'b1; w_pulse = 1'b1;
        end
        OP_CMP:  begin w_result = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH];
                       w_flags = 1'b1; w_pulse = 1'b1; end
        OP_READ: begin w_result = w_a; w_pulse = 1'b1; end
`ifdef ALU_MUL_EN
        OP_MUL:  w_mul_start = 1'b1;
`endif
        default: w_err = 1'b1;
      endcase
    end else begin
      w_err = 1'b0;
    end
  end

  // Register bank, result and flags; a completing multiply cannot collide with an accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_res_data  <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_res_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_res_valid <= w_pulse || w_mul_done;
      r_cmd_err   <= w_err;
      if (w_write) r_regs[i_cmd_dst] <= w_result;
      if (w_pulse) r_res_data <= w_result;
      if (w_flags) begin
        r_carry <= w_carry;
        r_zero  <= (w_result == {WIDTH{1'b0}});
      end
      if (w_mul_done) begin
        r_regs[w_mul_dst] <= w_mul_lo;
        r_res_data        <= w_mul_lo;
        r_carry           <= w_mul_hi;
        r_zero            <= (w_mul_lo == {WIDTH{1'b0}});
      end
    end
  end

  assign o_res_valid  = r_res_valid;
  assign o_res_data   = r_res_data;
  assign o_flag_carry = r_carry;
  assign o_flag_zero  = r_zero;
  assign o_cmd_err    = r_cmd_err;

endmodule

// File: tb/tb_alu_regfile.sv
// Directed bench for alu_regfile (WIDTH=8, NREGS=4); multiplier checks follow ALU_MUL_EN.
module tb_alu_regfile;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic [3:0] i_cmd_op;
  logic [1:0] i_cmd_dst;
  logic [1:0] i_cmd_srca;
  logic [1:0] i_cmd_srcb;
  logic [7:0] i_cmd_data;
  logic       o_res_valid;
  logic [7:0] o_res_data;
  logic       o_flag_carry;
  logic       o_flag_zero;
  logic       o_cmd_err;
  logic       o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_regfile #(.WIDTH(8), .NREGS(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_dst(i_cmd_dst), .i_cmd_srca(i_cmd_srca), .i_cmd_srcb(i_cmd_srcb),
    .i_cmd_data(i_cmd_data), .o_res_valid(o_res_valid), .o_res_data(o_res_data),
    .o_flag_carry(o_flag_carry), .o_flag_zero(o_flag_zero), .o_cmd_err(o_cmd_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present one command for a single edge; outputs are sampled 1 time unit after it.
  task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [7:0] data);
    i_cmd_op    = op;
    i_cmd_dst   = dst;
    i_cmd_srca  = sa;
    i_cmd_srcb  = sb;
    i_cmd_data  = data;
    i_cmd_valid = 1'b1;
    step();
    i_cmd_valid = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [7:0] d, input logic c, input logic z);
    check_eq({tag, " valid"}, 32'(o_res_valid), 32'd1);
    check_eq({tag, " data"}, 32'(o_res_data), 32'(d));
    check_eq({tag, " carry"}, 32'(o_flag_carry), 32'(c));
    check_eq({tag, " zero"}, 32'(o_flag_zero), 32'(z));
  endtask

`ifdef ALU_MUL_EN
  // Multiply r0*r1 into dst and confirm the pulse lands exactly WIDTH edges after accept.
  task automatic run_mul(input string tag, input logic [1:0] dst, input logic [7:0] d,
                         input logic c, input logic z);
    int early;
    int ready_hi;
    early    = 0;
    ready_hi = 0;
    issue(4'd11, dst, 2'd0, 2'd1, 8'd0);
    for (int k = 1; k < 8; k++) begin
      if (o_res_valid) early++;
      if (o_cmd_ready || !o_busy) ready_hi++;
      step();
    end
    if (o_res_valid) early++;
    if (o_cmd_ready || !o_busy) ready_hi++;
    step();
    check_eq({tag, " early pulses"}, 32'(early), 32'd0);
    check_eq({tag, " ready during mul"}, 32'(ready_hi), 32'd0);
    expect_res(tag, d, c, z);
    check_eq({tag, " ready after"}, 32'(o_cmd_ready), 32'd1);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_op = 4'd0;
    i_cmd_dst = 2'd0; i_cmd_srca = 2'd0; i_cmd_srcb = 2'd0; i_cmd_data = 8'd0;
    step();
    step();
    check_eq("rst data", 32'(o_res_data), 32'd0);
    check_eq("rst carry", 32'(o_flag_carry), 32'd0);
    check_eq("rst zero", 32'(o_flag_zero), 32'd0);
    check_eq("rst ready", 32'(o_cmd_ready), 32'd1);
    check_eq("rst busy", 32'(o_busy), 32'd0);
    check_eq("rst valid", 32'(o_res_valid), 32'd0);
    check_eq("rst err", 32'(o_cmd_err), 32'd0);
    i_rst = 1'b0;

    for (int r = 0; r < 4; r++) begin
      issue(4'd10, 2'd0, 2'(r), 2'd0, 8'd0);
      check_eq("read after rst valid", 32'(o_res_valid), 32'd1);
      check_eq("read after rst data", 32'(o_res_data), 32'd0);
    end

    issue(4'd1, 2'd0, 2'd0, 2'd0, 8'd200);
    check_eq("load r0", 32'(o_res_data), 32'd200);
    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'd100);
    issue(4'd2, 2'd2, 2'd0, 2'd1, 8'd0);
    expect_res("add 200+100", 8'd44, 1'b1, 1'b0);
    issue(4'd10, 2'd0, 2'd2, 2'd0, 8'd0);
    expect_res("read r2", 8'd44, 1'b1, 1'b0);

    issue(4'd15, 2'd2, 2'd0, 2'd1, 8'd0);
    check_eq("op15 err", 32'(o_cmd_err), 32'd1);
    check_eq("op15 valid", 32'(o_res_valid), 32'd0);
    check_eq("op15 data", 32'(o_res_data), 32'd44);
    check_eq("op15 carry", 32'(o_flag_carry), 32'd1);
    check_eq("op15 zero", 32'(o_flag_zero), 32'd0);
    issue(4'd0, 2'd2, 2'd0, 2'd1, 8'd0);
    check_eq("op15 err one cycle", 32'(o_cmd_err), 32'd0);
    check_eq("nop no pulse", 32'(o_res_valid), 32'd0);
    issue(4'd10, 2'd0, 2'd2, 2'd0, 8'd0);
    check_eq("r2 after op15", 32'(o_res_data), 32'd44);

    issue(4'd3, 2'd3, 2'd1, 2'd0, 8'd0);
    expect_res("sub 100-200", 8'd156, 1'b1, 1'b0);
    issue(4'd9, 2'd3, 2'd0, 2'd0, 8'd0);
    expect_res("cmp r0,r0", 8'd0, 1'b0, 1'b1);
    issue(4'd10, 2'd0, 2'd3, 2'd0, 8'd0);
    check_eq("r3 after cmp", 32'(o_res_data), 32'd156);

    issue(4'd1, 2'd0, 2'd0, 2'd0, 8'h81);
    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'd1);
    issue(4'd7, 2'd2, 2'd0, 2'd1, 8'd0);
    expect_res("shl 0x81<<1", 8'h02, 1'b1, 1'b0);
    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'd9);
    check_eq("load keeps carry", 32'(o_flag_carry), 32'd1);
    issue(4'd8, 2'd2, 2'd0, 2'd1, 8'd0);
    expect_res("shr 0x81>>9", 8'd0, 1'b0, 1'b1);
    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'd0);
    issue(4'd7, 2'd2, 2'd0, 2'd1, 8'd0);
    expect_res("shl by 0", 8'h81, 1'b0, 1'b0);
    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'd8);
    issue(4'd7, 2'd2, 2'd0, 2'd1, 8'd0);
    expect_res("shl by 8", 8'd0, 1'b0, 1'b1);
    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'd1);
    issue(4'd8, 2'd2, 2'd0, 2'd1, 8'd0);
    expect_res("shr 0x81>>1", 8'h40, 1'b1, 1'b0);

    issue(4'd1, 2'd3, 2'd0, 2'd0, 8'hF0);
    issue(4'd6, 2'd2, 2'd0, 2'd3, 8'd0);
    expect_res("xor", 8'h71, 1'b0, 1'b0);
    issue(4'd4, 2'd2, 2'd0, 2'd3, 8'd0);
    expect_res("and", 8'h80, 1'b0, 1'b0);
    issue(4'd5, 2'd2, 2'd0, 2'd3, 8'd0);
    expect_res("or", 8'hF1, 1'b0, 1'b0);
    issue(4'd2, 2'd0, 2'd0, 2'd0, 8'd0);
    expect_res("add r0=r0+r0", 8'h02, 1'b1, 1'b0);
    issue(4'd10, 2'd0, 2'd0, 2'd0, 8'd0);
    check_eq("read r0 after self add", 32'(o_res_data), 32'h02);

`ifdef ALU_MUL_EN
    issue(4'd1, 2'd0, 2'd0, 2'd0, 8'd15);
    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'd17);
    run_mul("mul 15x17", 2'd2, 8'd255, 1'b0, 1'b0);
    issue(4'd10, 2'd0, 2'd2, 2'd0, 8'd0);
    check_eq("read mul r2", 32'(o_res_data), 32'd255);
    issue(4'd1, 2'd0, 2'd0, 2'd0, 8'd16);
    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'd16);
    run_mul("mul 16x16", 2'd3, 8'd0, 1'b1, 1'b1);

    issue(4'd1, 2'd2, 2'd0, 2'd0, 8'h5A);
    issue(4'd11, 2'd2, 2'd0, 2'd1, 8'd0);
    step();
    step();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check_eq("mul abort valid", 32'(o_res_valid), 32'd0);
    check_eq("mul abort ready", 32'(o_cmd_ready), 32'd1);
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
        if (o_res_valid) pulses++;
        step();
      end
      check_eq("mul abort late pulses", 32'(pulses), 32'd0);
    end
    issue(4'd10, 2'd0, 2'd2, 2'd0, 8'd0);
    check_eq("mul abort dst", 32'(o_res_data), 32'd0);
`else
    issue(4'd11, 2'd2, 2'd0, 2'd1, 8'd0);
    check_eq("op11 err", 32'(o_cmd_err), 32'd1);
    check_eq("op11 valid", 32'(o_res_valid), 32'd0);
    check_eq("op11 data", 32'(o_res_data), 32'h02);
    check_eq("op11 carry", 32'(o_flag_carry), 32'd1);
    check_eq("op11 ready", 32'(o_cmd_ready), 32'd1);
    issue(4'd10, 2'd0, 2'd2, 2'd0, 8'd0);
    check_eq("r2 after op11", 32'(o_res_data), 32'hF1);
`endif

    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'h33);
    i_rst = 1'b1;
    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'h77);
    i_rst = 1'b0;
    check_eq("rst beats cmd valid", 32'(o_res_valid), 32'd0);
    check_eq("rst beats cmd data", 32'(o_res_data), 32'd0);
    issue(4'd10, 2'd0, 2'd1, 2'd0, 8'd0);
    check_eq("r1 after rst", 32'(o_res_data), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_regfile.md
# alu_regfile

Parametrised register-file ALU: a bank of `NREGS` operand registers of `WIDTH` bits, driven by a valid/ready command port with 3-address operations (dst ← srcA op srcB). It adds XOR, shifts, compare, carry/zero flags, an error pulse and an optional multi-cycle multiplier. It sits between the pin-level command decoder and the output mux, and is the general successor to the fixed 8-bit two-operand ALU.

## Interface
- `WIDTH`, 8, datapath and register width (≥4)
- `NREGS`, 4, number of operand registers (power of two, ≥2); `AW = $clog2(NREGS)`
- `clk` in 1, sole clock, rising edge
- `rst` in 1, reset, synchronous, active-high
- `cmd_valid` in 1, command present
- `cmd_ready` out 1, block can accept a command
- `cmd_op` in 4, opcode
- `cmd_dst` / `cmd_srca` / `cmd_srcb` in AW each, register indices
- `cmd_data` in WIDTH, immediate for LOAD
- `res_valid` out 1, one-cycle pulse: `res_data`/flags updated
- `res_data` out WIDTH, last result, held between pulses
- `flag_carry` out 1, carry/borrow/shift-out/overflow
- `flag_zero` out 1, last result == 0
- `cmd_err` out 1, one-cycle pulse on illegal opcode
- `busy` out 1, multi-cycle op in progress (equals `!cmd_ready`)

## Operation
- Accept = `cmd_valid && cmd_ready`. Operands are read from `reg[srca]`/`reg[srcb]` at the accept edge.
- Opcodes:
  - 0 NOP: nothing, no pulse.
  - 1 LOAD: `reg[dst]=cmd_data`, res_data=cmd_data, flags unchanged.
  - 2 ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 3 SUB: A−B mod 2^WIDTH, carry = borrow (A<B unsigned).
  - 4 AND, 5 OR, 6 XOR: carry cleared.
  - 7 SHL, 8 SHR (logical): amount = B unsigned; carry = last bit shifted out; amount 0 → result A, carry 0; amount ≥ WIDTH → result 0, carry 0.
  - 9 CMP: as SUB, sets flags and res_data, no register write.
  - 10 READ: res_data=reg[srca], flags unchanged, no write.
  - 11 MUL: see Configuration. 12–15: illegal.
- For ops 2–8 and 11: result written to `reg[dst]` and `res_data`; zero flag updated from the result. Ops 1–11 pulse `res_valid`.
- Illegal op: `cmd_err` pulses, no `res_valid`, registers/flags/`res_data` unchanged.
- FSM: IDLE (`cmd_ready=1`) and MUL (`cmd_ready=0`). IDLE→MUL on accepted MUL; MUL→IDLE after WIDTH shift-add steps.
- `dst` may equal `srca`/`srcb`: operands are sampled before the write.

## Timing
- Single-cycle ops: accept at edge N → register write, `res_data`, flags and `res_valid` at edge N; visible cycle N..N+1. Back-to-back accepts are allowed every cycle.
- A command accepted at edge N+1 reads the value written at edge N (no hazard).
- MUL: accept at edge N; `cmd_ready` low for WIDTH cycles; result and `res_valid` at edge N+WIDTH; `cmd_ready` high again after that edge.
- Commands presented while `cmd_ready=0` are not accepted and must be held by the sender.
- Reset: all registers, `res_data`, flags = 0; `res_valid`, `cmd_err`, `busy` = 0; `cmd_ready` = 1; FSM = IDLE. Reset during MUL aborts it with no write and no pulse. `rst` overrides a simultaneous `cmd_valid`.

## Configuration
- `ALU_MUL_EN` defined:
  - Opcode 11 is an unsigned shift-add multiply, WIDTH cycles.
  - dst = low WIDTH bits of the product; carry = 1 if any high bits are nonzero; zero from the low bits.
- `ALU_MUL_EN` undefined:
  - Opcode 11 is illegal and pulses `cmd_err`.
  - No MUL state; `cmd_ready` is tied to 1 (0 only during reset is not required); `busy` is tied to 0.

## Test plan
All scenarios use WIDTH=8, NREGS=4.
- Reset: hold `rst` 2 cycles → `res_data`=0, carry=0, zero=0, `cmd_ready`=1; READ r0..r3 → 0 each.
- LOAD r0=200, LOAD r1=100, ADD r2=r0+r1 → `res_data`=44, carry=1, zero=0. READ r2 on the next cycle → 44.
- SUB r3=r1−r0 → 156, carry=1. CMP r0,r0 → zero=1, carry=0, r3 still 156.
- LOAD r0=0x81, r1=1; SHL r2=r0<<r1 → 0x02, carry=1. LOAD r1=9; SHR → 0, carry=0, zero=1.
- `ALU_MUL_EN`:
  - 15×17 → 255, carry=0, `res_valid` exactly 8 cycles after accept, `cmd_ready` low during those 8 cycles.
  - 16×16 → 0, carry=1, zero=1.
  - Assert `rst` at cycle 4 of a MUL → no `res_valid`, `cmd_ready`=1 next cycle, dst=0.
- Opcode 15 → `cmd_err` one-cycle pulse, no `res_valid`, registers/flags unchanged. Without `ALU_MUL_EN`, opcode 11 behaves identically.
